// File: rtl/bus_buffer_ctl_pkg.sv
// ============================================================================
// Module   : bus_buffer_ctl_pkg
// Brief    : Shared state encoding and counter sizing helper for bus_buffer_ctl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_buffer_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    // Width of a counter that must hold the value max_val; never below one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_buffer_ctl_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request after 'last'.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import bus_buffer_ctl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 valid
);

    localparam int c_IDX_W = $clog2(N);

    always_comb begin
        int k;
        k         = 0;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        // Scan last+1 .. last (mod N); the first set bit wins.
        for (int i = 1; i <= N; i++) begin
            k = int'(last) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid && req[k[c_IDX_W-1:0]]) begin
                valid                   = 1'b1;
                grant[k[c_IDX_W-1:0]]   = 1'b1;
                grant_idx               = k[c_IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_buffer_ctl.sv
// ============================================================================
// Module   : bus_buffer_ctl
// Brief    : Round-robin sequencer for octal bus driver banks (EN then OE,
//            turnaround dead time between owners, optional hold timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_buffer_ctl
    import bus_buffer_ctl_pkg::*;
#(
    parameter int N         = 4,
    parameter int SETUP_CYC = 1,
    parameter int TURN_CYC  = 2,
    parameter int HOLD_MAX  = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] rel,
    output logic [N-1:0] gnt,
    output logic [N-1:0] buf_en_n,
    output logic [N-1:0] buf_oe_n,
    output logic         busy,
    output logic         tmo
);

    localparam int c_IDX_W = $clog2(N);
    localparam int c_SET_W = cnt_width(SETUP_CYC);
    localparam int c_TRN_W = cnt_width(TURN_CYC);
    localparam int c_HLD_W = cnt_width(HOLD_MAX);

    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETUP_CYC);
    localparam logic [c_TRN_W-1:0] c_TRN_LAST = c_TRN_W'(TURN_CYC);
    localparam logic [c_HLD_W-1:0] c_HLD_LAST = c_HLD_W'(HOLD_MAX);
    localparam logic [c_HLD_W-1:0] c_HLD_SAT  = '1;
    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(N - 1);
    localparam logic               c_HLD_EN   = (HOLD_MAX != 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N-1:0]         r_owner;
    logic [N-1:0]         w_owner_nxt;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [c_SET_W-1:0]   r_setup_cnt;
    logic [c_SET_W-1:0]   w_setup_nxt;
    logic [c_TRN_W-1:0]   r_turn_cnt;
    logic [c_TRN_W-1:0]   w_turn_nxt;
    logic [c_HLD_W-1:0]   r_hold_cnt;
    logic [c_HLD_W-1:0]   w_hold_nxt;

    logic [N-1:0]         r_gnt;
    logic [N-1:0]         r_en_n;
    logic [N-1:0]         r_oe_n;
    logic                 r_busy;
    logic                 r_tmo;
    logic [N-1:0]         w_gnt_nxt;
    logic [N-1:0]         w_en_n_nxt;
    logic [N-1:0]         w_oe_n_nxt;
    logic                 w_busy_nxt;
    logic                 w_tmo_nxt;

    logic [N-1:0]         w_arb_gnt;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_valid;
    logic                 w_own_req;
    logic                 w_own_rel;
    logic                 w_hold_hit;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req       (req),
        .last      (r_last),
        .grant     (w_arb_gnt),
        .grant_idx (w_arb_idx),
        .valid     (w_arb_valid)
    );

    // Only the current owner's req/rel lines matter once a bank is chosen.
    assign w_own_req  = |(req & r_owner);
    assign w_own_rel  = |(rel & r_owner);
    assign w_hold_hit = c_HLD_EN && (r_hold_cnt == c_HLD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_setup_nxt = r_setup_cnt;
        w_turn_nxt  = r_turn_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_tmo_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_owner_nxt = w_arb_gnt;
                    w_last_nxt  = w_arb_idx;
                    w_setup_nxt = c_SET_W'(1);
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!w_own_req) begin
                    w_owner_nxt = '0;
                    w_turn_nxt  = c_TRN_W'(1);
                    w_state_nxt = ST_TURN;
                end else if (r_setup_cnt == c_SET_LAST) begin
                    w_hold_nxt  = c_HLD_W'(1);
                    w_state_nxt = ST_DRIVE;
                end else begin
                    w_setup_nxt = r_setup_cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                // A timeout pulses tmo even when rel/!req coincide with it.
                if (w_hold_hit || w_own_rel || !w_own_req) begin
                    w_tmo_nxt   = w_hold_hit;
                    w_owner_nxt = '0;
                    w_turn_nxt  = c_TRN_W'(1);
                    w_state_nxt = ST_TURN;
                end else if (r_hold_cnt != c_HLD_SAT) begin
                    w_hold_nxt  = r_hold_cnt + 1'b1;
                end
            end
            ST_TURN: begin
                if (r_turn_cnt == c_TRN_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_turn_nxt  = r_turn_cnt + 1'b1;
                end
            end
            default: begin
                w_owner_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        w_en_n_nxt = '1;
        w_oe_n_nxt = '1;
        w_gnt_nxt  = '0;
        if (w_state_nxt == ST_SETUP || w_state_nxt == ST_DRIVE) begin
            w_en_n_nxt = ~w_owner_nxt;
        end
        if (w_state_nxt == ST_DRIVE) begin
            w_oe_n_nxt = ~w_owner_nxt;
            w_gnt_nxt  = w_owner_nxt;
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_last      <= c_LAST_RST;
            r_setup_cnt <= '0;
            r_turn_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_en_n      <= '1;
            r_oe_n      <= '1;
            r_busy      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_setup_cnt <= w_setup_nxt;
            r_turn_cnt  <= w_turn_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_en_n      <= w_en_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_busy      <= w_busy_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign buf_en_n = r_en_n;
    assign buf_oe_n = r_oe_n;
    assign busy     = r_busy;
    assign tmo      = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_bus_buffer_ctl.sv
// ============================================================================
// Module   : tb_bus_buffer_ctl
// Brief    : Directed and randomized checks of bus_buffer_ctl against a
//            behavioural owner/countdown model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_buffer_ctl;

    localparam int N         = 4;
    localparam int SETUP_CYC = 1;
    localparam int TURN_CYC  = 2;
    localparam int HOLD_MAX  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] rel;
    logic [N-1:0] gnt;
    logic [N-1:0] buf_en_n;
    logic [N-1:0] buf_oe_n;
    logic         busy;
    logic         tmo;

    int total = 0;
    int bad   = 0;

    // Model: owner index (-1 = nobody), countdowns for setup and turnaround.
    int m_owner;
    int m_last;
    int m_setup_left;
    int m_drive_n;
    int m_turn_left;
    bit m_tmo;

    int cyc;
    int last_oe_cyc;
    bit prev_oe_any;

    bus_buffer_ctl #(
        .N         (N),
        .SETUP_CYC (SETUP_CYC),
        .TURN_CYC  (TURN_CYC),
        .HOLD_MAX  (HOLD_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .rel      (rel),
        .gnt      (gnt),
        .buf_en_n (buf_en_n),
        .buf_oe_n (buf_oe_n),
        .busy     (busy),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    task automatic model_reset();
        m_owner      = -1;
        m_last       = N - 1;
        m_setup_left = 0;
        m_drive_n    = 0;
        m_turn_left  = 0;
        m_tmo        = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        m_tmo = 1'b0;
        if (m_turn_left > 0) begin
            m_turn_left--;
        end else if (m_owner < 0) begin
            for (int s = 1; s <= N; s++) begin
                int c;
                c = (m_last + s) % N;
                if ((r & onehot(c)) != '0) begin
                    m_owner      = c;
                    m_last       = c;
                    m_setup_left = SETUP_CYC;
                    break;
                end
            end
        end else if (m_setup_left > 0) begin
            if ((r & onehot(m_owner)) == '0) begin
                m_owner     = -1;
                m_turn_left = TURN_CYC;
            end else begin
                m_setup_left--;
                if (m_setup_left == 0) m_drive_n = 1;
            end
        end else begin
            bit hit;
            hit = (HOLD_MAX != 0) && (m_drive_n >= HOLD_MAX);
            if (hit || (l & onehot(m_owner)) != '0 || (r & onehot(m_owner)) == '0) begin
                m_tmo       = hit;
                m_owner     = -1;
                m_turn_left = TURN_CYC;
            end else begin
                m_drive_n++;
            end
        end
    endtask

    task automatic compare_all(input logic rs);
        bit           drv;
        bit           oe_any;
        logic [N-1:0] e_en, e_oe, e_gnt;
        drv   = (m_owner >= 0) && (m_setup_left == 0);
        e_en  = (m_owner >= 0) ? ~onehot(m_owner) : '1;
        e_oe  = drv ? ~onehot(m_owner) : '1;
        e_gnt = drv ? onehot(m_owner) : '0;
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("buf_en_n", 32'(buf_en_n), 32'(e_en));
        check("buf_oe_n", 32'(buf_oe_n), 32'(e_oe));
        check("busy",     32'(busy),     32'((m_owner >= 0) || (m_turn_left > 0)));
        check("tmo",      32'(tmo),      32'(m_tmo));
        check("one_oe_low",   32'($countones(~buf_oe_n) <= 1), 32'd1);
        check("oe_needs_en",  32'((~buf_oe_n & buf_en_n) == '0), 32'd1);
        check("gnt_is_not_oe", 32'(gnt == ~buf_oe_n), 32'd1);
        oe_any = (buf_oe_n != '1);
        if (rs) begin
            last_oe_cyc = -1000;
        end else if (oe_any && !prev_oe_any) begin
            check("turn_gap", 32'((cyc - last_oe_cyc - 1) >= (TURN_CYC + 1)), 32'd1);
        end
        if (oe_any) last_oe_cyc = cyc;
        prev_oe_any = oe_any;
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
        req   = r;
        rel   = l;
        reset = rs;
        @(posedge clk);
        if (rs) model_reset();
        else    model_step(r, l);
        #1;
        cyc++;
        compare_all(rs);
    endtask

    task automatic wait_grant(input logic [N-1:0] r, output int idx);
        int n;
        n   = 0;
        idx = -1;
        while (gnt == '0 && n < 20) begin
            tick(r, '0, 1'b0);
            n++;
        end
        check("wait_grant", 32'(gnt != '0), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (gnt == onehot(i)) idx = i;
        end
    endtask

    initial begin
        int           got;
        int           ng, nt, tt, rg;
        logic [N-1:0] rr, flip, rl;
        logic         rs;

        req = '0; rel = '0; reset = 1'b1;
        cyc = 0; last_oe_cyc = -1000; prev_oe_any = 1'b0;
        model_reset();

        // Reset state
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h0, 4'h0, 1'b1);
        check("rst_en_n", 32'(buf_en_n), 32'hF);
        check("rst_oe_n", 32'(buf_oe_n), 32'hF);
        check("rst_gnt",  32'(gnt),      32'h0);
        check("rst_busy", 32'(busy),     32'h0);

        // Single requester latency and release
        tick(4'h1, 4'h0, 1'b0);
        check("t1_en_c1", 32'(buf_en_n), 32'hE);
        tick(4'h1, 4'h0, 1'b0);
        check("t1_oe_c2",  32'(buf_oe_n), 32'hE);
        check("t1_gnt_c2", 32'(gnt),      32'h1);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h0, 4'h1, 1'b0);
        check("t1_en_c6", 32'(buf_en_n), 32'hF);
        check("t1_oe_c6", 32'(buf_oe_n), 32'hF);
        tick(4'h0, 4'h0, 1'b0);
        tick(4'h0, 4'h0, 1'b0);
        check("t1_busy_c8", 32'(busy), 32'h0);

        // All request, each owner releases after three DRIVE cycles
        tick(4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_grant(4'hF, got);
            check("t2_order", 32'(got), 32'(k % N));
            tick(4'hF, 4'h0, 1'b0);
            tick(4'hF, 4'h0, 1'b0);
            tick(4'hF, gnt, 1'b0);
        end

        // Hold timeout
        tick(4'h0, 4'h0, 1'b1);
        ng = 0; nt = 0; tt = -1; rg = -1;
        for (int k = 1; k <= 9; k++) begin
            tick(4'h4, 4'h0, 1'b0);
            if (gnt == 4'h4) ng++;
            if (tmo) begin
                nt++;
                tt = k;
            end
            if (tt > 0 && k > tt && buf_en_n == 4'hB && rg < 0) rg = k - tt;
        end
        check("t3_gnt_cycles", 32'(ng), 32'(HOLD_MAX));
        check("t3_tmo_pulses", 32'(nt), 32'd1);
        check("t3_regrant",    32'(rg), 32'(TURN_CYC + 1));

        // Request withdrawn during SETUP
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h2, 4'h0, 1'b0);
        check("t4_en_setup", 32'(buf_en_n), 32'hD);
        tick(4'h0, 4'h0, 1'b0);
        check("t4_oe_abort", 32'(buf_oe_n), 32'hF);
        check("t4_busy_turn", 32'(busy), 32'h1);
        tick(4'h0, 4'h0, 1'b0);
        tick(4'h0, 4'h0, 1'b0);
        check("t4_idle", 32'(busy), 32'h0);

        // Reset during DRIVE
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h1, 4'h0, 1'b0);
        tick(4'h1, 4'h0, 1'b0);
        check("t5_driving", 32'(gnt), 32'h1);
        tick(4'h1, 4'h0, 1'b1);
        check("t5_rst_en", 32'(buf_en_n), 32'hF);
        check("t5_rst_oe", 32'(buf_oe_n), 32'hF);
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        tick(4'h8, 4'h0, 1'b0);
        check("t5_new_en", 32'(buf_en_n), 32'h7);
        tick(4'h8, 4'h0, 1'b0);
        check("t5_new_gnt", 32'(gnt), 32'h8);

        // Non-owner release is ignored
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h9, 4'h0, 1'b0);
        tick(4'h9, 4'h0, 1'b0);
        check("t6_owner0", 32'(gnt), 32'h1);
        tick(4'h9, 4'h8, 1'b0);
        check("t6_ignore_rel3", 32'(gnt), 32'h1);
        tick(4'h9, 4'h1, 1'b0);
        check("t6_own_rel", 32'(gnt), 32'h0);
        wait_grant(4'h9, got);
        check("t6_next_owner", 32'(got), 32'd3);

        // Randomized traffic
        tick(4'h0, 4'h0, 1'b1);
        rr = '0;
        for (int k = 0; k < 600; k++) begin
            flip = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rl   = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
            rs   = ($urandom_range(0, 99) == 0);
            rr   = rr ^ flip;
            tick(rr, rl, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
